// File: rtl/mdu_controller.sv
// Iterative multiply/divide unit holding the architectural HI/LO registers.
// One shift-add (MUL) or restoring shift-subtract (DIV) step per cycle, then a sign-fix cycle.
module mdu_controller #(
  parameter int unsigned ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StartE,
  input  logic [1:0]  OpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        MtHiE,
  input  logic        MtLoE,
  input  logic        MduUseD,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        BusyE,
  output logic        StallMDU,
  output logic        DivZero
);

  localparam int unsigned W    = 32;
  localparam int unsigned CntW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} stateT;

  stateT           state, stateNext;
  logic [CntW-1:0] count;
  logic [W-1:0]    accHi, accLo, opB;
  logic            signQ, signR, isMul;

  logic            isSigned, divByZero;
  logic [W-1:0]    absA, absB;
  logic [W:0]      mulSum, divTrial;
  logic            divFits;
  logic [2*W-1:0]  prodFix;
  logic [W-1:0]    quoFix, remFix;

  // Issue-time operand decode
  always_comb begin
    isSigned  = ~OpE[0];
    divByZero = StartE & OpE[1] & (SrcBE == '0);
    absA      = (isSigned & SrcAE[W-1]) ? -SrcAE : SrcAE;
    absB      = (isSigned & SrcBE[W-1]) ? -SrcBE : SrcBE;
  end

  // Per-cycle arithmetic step and final sign correction
  always_comb begin
    mulSum   = {1'b0, accHi} + {1'b0, (accLo[0] ? opB : '0)};
    divTrial = {accHi, accLo[W-1]} - {1'b0, opB};
    divFits  = ~divTrial[W];
    prodFix  = signQ ? -{accHi, accLo} : {accHi, accLo};
    quoFix   = signQ ? -accLo : accLo;
    remFix   = signR ? -accHi : accHi;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (StartE) begin
          if (!OpE[1])        stateNext = MUL;
          else if (divByZero) stateNext = FIX;
          else                stateNext = DIV;
        end
      end
      MUL, DIV: begin
        if (count == CntW'(ITER - 1)) stateNext = FIX;
      end
      FIX:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign StallMDU = (state != IDLE) & MduUseD;

  // Datapath, HI/LO and status registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      accHi   <= '0;
      accLo   <= '0;
      opB     <= '0;
      signQ   <= 1'b0;
      signR   <= 1'b0;
      isMul   <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      BusyE   <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      BusyE   <= (stateNext != IDLE);
      DivZero <= (state == IDLE) & divByZero;
      case (state)
        IDLE: begin
          count <= '0;
          if (StartE) begin
            isMul <= ~OpE[1];
            signQ <= isSigned & (SrcAE[W-1] ^ SrcBE[W-1]) & ~divByZero;
            signR <= isSigned & SrcAE[W-1] & ~divByZero;
            // Divide by zero preloads the architectural result straight into the accumulator
            if (divByZero) begin
              accHi <= SrcAE;
              accLo <= '1;
              opB   <= '0;
            end else if (!OpE[1]) begin
              accHi <= '0;
              accLo <= absB;
              opB   <= absA;
            end else begin
              accHi <= '0;
              accLo <= absA;
              opB   <= absB;
            end
          end else begin
            if (MtHiE) HI <= SrcAE;
            if (MtLoE) LO <= SrcAE;
          end
        end
        MUL: begin
          {accHi, accLo} <= {mulSum, accLo[W-1:1]};
          count          <= count + CntW'(1);
        end
        DIV: begin
          accHi <= divFits ? divTrial[W-1:0] : {accHi[W-2:0], accLo[W-1]};
          accLo <= {accLo[W-2:0], divFits};
          count <= count + CntW'(1);
        end
        FIX: begin
          count <= '0;
          if (isMul) begin
            {HI, LO} <= prodFix;
          end else begin
            HI <= remFix;
            LO <= quoFix;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_controller.sv
// Self-checking bench for mdu_controller: arithmetic reference model with a
// cycle-count latency model, compared every cycle, plus directed literal checks.
module tb_mdu_controller;

  localparam int unsigned ITER = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        StartE = 1'b0;
  logic [1:0]  OpE = 2'b00;
  logic [31:0] SrcAE = '0;
  logic [31:0] SrcBE = '0;
  logic        MtHiE = 1'b0;
  logic        MtLoE = 1'b0;
  logic        MduUseD = 1'b0;
  logic [31:0] HI, LO;
  logic        BusyE, StallMDU, DivZero;

  mdu_controller #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .StartE(StartE), .OpE(OpE), .SrcAE(SrcAE), .SrcBE(SrcBE),
    .MtHiE(MtHiE), .MtLoE(MtLoE), .MduUseD(MduUseD), .HI(HI), .LO(LO),
    .BusyE(BusyE), .StallMDU(StallMDU), .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {HI, LO} that a completed operation must leave behind
  function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      2'b10: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else        p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  logic [31:0] mHi = '0, mLo = '0;
  logic [63:0] mPend = '0;
  logic        mDz = 1'b0;
  int          mLeft = 0;

  // Reference model: result lands after ITER+1 busy cycles (1 for divide by zero)
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mHi = '0; mLo = '0; mLeft = 0; mDz = 1'b0;
    end else begin
      mDz = 1'b0;
      if (mLeft > 0) begin
        mLeft--;
        if (mLeft == 0) {mHi, mLo} = mPend;
      end else if (StartE) begin
        mPend = refResult(OpE, SrcAE, SrcBE);
        if (OpE[1] && SrcBE == 0) begin
          mLeft = 1;
          mDz   = 1'b1;
        end else begin
          mLeft = int'(ITER) + 1;
        end
      end else begin
        if (MtHiE) mHi = SrcAE;
        if (MtLoE) mLo = SrcAE;
      end
    end
  end

  always @(negedge clk) begin
    chk("HI", HI, mHi);
    chk("LO", LO, mLo);
    chk("BusyE", 32'(BusyE), 32'(mLeft > 0));
    chk("DivZero", 32'(DivZero), 32'(mDz));
    chk("StallMDU", 32'(StallMDU), 32'((mLeft > 0) && MduUseD));
  end

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic mt, output int n, output logic dz);
    StartE = 1'b1; OpE = op; SrcAE = a; SrcBE = b; MtHiE = mt;
    @(posedge clk); #1;
    StartE = 1'b0; MtHiE = 1'b0;
    dz = DivZero;
    n  = 0;
    while (BusyE && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 200) chk("busyTimeout", 32'(n), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    logic dz;

    #2 reset = 1'b0;
    #1;
    chk("rstHI", HI, 32'h0);
    chk("rstLO", LO, 32'h0);
    chk("rstBusy", 32'(BusyE), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // MULT 7 * -3
    issue(2'b00, 32'd7, 32'hFFFFFFFD, 1'b0, n, dz);
    chk("t1Busy", 32'(n), 32'd33);
    chk("t1Dz", 32'(dz), 32'd0);
    chk("t1HI", HI, 32'hFFFFFFFF);
    chk("t1LO", LO, 32'hFFFFFFEB);

    // MULTU max * max
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, n, dz);
    chk("t2HI", HI, 32'hFFFFFFFE);
    chk("t2LO", LO, 32'h00000001);

    // DIV / DIVU of -7 by 2
    issue(2'b10, 32'hFFFFFFF9, 32'd2, 1'b0, n, dz);
    chk("t3sHI", HI, 32'hFFFFFFFF);
    chk("t3sLO", LO, 32'hFFFFFFFD);
    issue(2'b11, 32'hFFFFFFF9, 32'd2, 1'b0, n, dz);
    chk("t3uHI", HI, 32'h00000001);
    chk("t3uLO", LO, 32'h7FFFFFFC);

    // Divide by zero
    issue(2'b11, 32'h1234, 32'h0, 1'b0, n, dz);
    chk("t4Busy", 32'(n), 32'd1);
    chk("t4Dz", 32'(dz), 32'd1);
    chk("t4HI", HI, 32'h00001234);
    chk("t4LO", LO, 32'hFFFFFFFF);
    issue(2'b10, 32'h80000005, 32'h0, 1'b0, n, dz);
    chk("dzSignedHI", HI, 32'h80000005);

    // Signed overflow wraps
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, n, dz);
    chk("ovfHI", HI, 32'h0);
    chk("ovfLO", LO, 32'h80000000);

    // Mixed-sign divide: -100 / 7 and 100 / -7
    issue(2'b10, 32'hFFFFFF9C, 32'd7, 1'b0, n, dz);
    chk("divNegHI", HI, 32'hFFFFFFFE);
    chk("divNegLO", LO, 32'hFFFFFFF2);
    issue(2'b10, 32'd100, 32'hFFFFFFF9, 1'b0, n, dz);
    chk("divNbHI", HI, 32'h00000002);
    chk("divNbLO", LO, 32'hFFFFFFF2);

    // StartE wins over a simultaneous mthi
    issue(2'b01, 32'd2, 32'd3, 1'b1, n, dz);
    chk("prioHI", HI, 32'h0);
    chk("prioLO", LO, 32'd6);

    // MduUseD during a MULT, with a second StartE while busy
    StartE = 1'b1; OpE = 2'b00; SrcAE = 32'd5; SrcBE = 32'd6;
    @(posedge clk); #1 StartE = 1'b0;
    @(posedge clk); #1 MduUseD = 1'b1;
    @(posedge clk); #1;
    chk("t5Stall", 32'(StallMDU), 32'd1);
    StartE = 1'b1; OpE = 2'b01; SrcAE = 32'hFFFFFFFF; SrcBE = 32'hFFFFFFFF;
    @(posedge clk); #1 StartE = 1'b0;
    guard = 0;
    while (BusyE && guard < 200) begin
      chk("t5StallHeld", 32'(StallMDU), 32'd1);
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 200) chk("t5Timeout", 32'(guard), 32'd0);
    chk("t5StallEnd", 32'(StallMDU), 32'd0);
    chk("t5HI", HI, 32'h0);
    chk("t5LO", LO, 32'd30);
    MduUseD = 1'b0;

    // Reset mid-divide after mthi/mtlo preload
    MtHiE = 1'b1; MtLoE = 1'b1; SrcAE = 32'hAAAA5555;
    @(posedge clk); #1 MtHiE = 1'b0; MtLoE = 1'b0;
    chk("t6PreHI", HI, 32'hAAAA5555);
    chk("t6PreLO", LO, 32'hAAAA5555);
    StartE = 1'b1; OpE = 2'b10; SrcAE = 32'd100; SrcBE = 32'd7;
    @(posedge clk); #1 StartE = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6RstHI", HI, 32'h0);
    chk("t6RstLO", LO, 32'h0);
    chk("t6RstBusy", 32'(BusyE), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    issue(2'b00, 32'd3, 32'd4, 1'b0, n, dz);
    chk("t6Busy", 32'(n), 32'd33);
    chk("t6HI", HI, 32'h0);
    chk("t6LO", LO, 32'd12);

    // Plain mtlo then mthi
    MtLoE = 1'b1; SrcAE = 32'h0BADF00D;
    @(posedge clk); #1 MtLoE = 1'b0;
    MtHiE = 1'b1; SrcAE = 32'h12345678;
    @(posedge clk); #1 MtHiE = 1'b0;
    chk("mtHI", HI, 32'h12345678);
    chk("mtLO", LO, 32'h0BADF00D);

    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_controller.md
MDU_CONTROLLER -- requirements
Module: mdu_controller

Interface
REQ-001 SHALL have parameter ITER, default 32, meaning number of iteration cycles per multiply/divide (fixed at operand width).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port StartE  input  1  E-stage MDU instruction issue, already qualified by flush.
REQ-005 SHALL have port OpE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have port SrcAE  input  32  rs operand (multiplicand/dividend).
REQ-007 SHALL have port SrcBE  input  32  rt operand (multiplier/divisor).
REQ-008 SHALL have port MtHiE, MtLoE  input  1 each  mthi/mtlo write of SrcAE.
REQ-009 SHALL have port MduUseD  input  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL have port HI, LO  output  32 each  architectural HI/LO registers.
REQ-011 SHALL have port BusyE  output  1  operation in progress (registered).
REQ-012 SHALL have port StallMDU  output  1  stall request to hazard logic (StallF/StallD/FlushE).
REQ-013 SHALL have port DivZero  output  1  one-cycle pulse, divide by zero detected.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, FIX.
- IDLE -> MUL: StartE & OpE[1]==0. IDLE -> DIV: StartE & OpE[1]==1 & SrcBE!=0. IDLE -> FIX: StartE & DIV/DIVU & SrcBE==0.
- MUL/DIV -> FIX: iteration counter reaches ITER-1. FIX -> IDLE always.
REQ-015 SHALL, on the start edge, latch the operands: absolute values for signed ops, raw values for unsigned ops. It SHALL also latch the result-sign bits: product/quotient sign = A[31]^B[31], remainder sign = A[31]; both forced to 0 for unsigned ops.
REQ-016 SHALL in MUL perform one shift-add step per cycle on a 64-bit accumulator; in DIV, one restoring shift-subtract step per cycle. The 5-bit counter SHALL run 0..ITER-1.
REQ-017 SHALL in FIX apply two's-complement sign correction per REQ-015 and write HI/LO at the end of the FIX cycle. MULT/MULTU: HI=product[63:32], LO=product[31:0]. DIV/DIVU: HI=remainder, LO=quotient.
REQ-018 Latency SHALL be as follows.
- Start edge is edge 1; HI/LO update on edge ITER+2 (34).
- BusyE SHALL be high from edge 1 through edge ITER+2, i.e. 33 cycles.
- For divide by zero, HI/LO update on edge 2.
REQ-019 SHALL, on divide by zero, write HI=SrcAE (unsigned value as issued) and LO=32'hFFFFFFFF, and pulse DivZero high during the FIX cycle.
REQ-020 SHALL wrap the signed overflow case 0x80000000 / 0xFFFFFFFF to LO=0x80000000, HI=0, with no exception.
REQ-021 SHALL define StallMDU = BusyE & MduUseD, combinationally. StallMDU SHALL be 0 in the FIX cycle only if FIX writes HI/LO combinationally visible to D; otherwise it SHALL remain high. Decided: it remains high, i.e. StallMDU = (state!=IDLE) & MduUseD.
REQ-022 SHALL accept StartE, MtHiE and MtLoE only in IDLE; in all other states they SHALL be ignored, and hazard logic guarantees they do not occur.
REQ-023 SHALL, when StartE and MtHiE/MtLoE are both asserted in IDLE, give StartE priority; the mt write SHALL be dropped.
REQ-024 SHALL write HI or LO from SrcAE on the edge for MtHiE/MtLoE in IDLE, with no busy cycle.
REQ-025 HI/LO SHALL be unchanged during MUL/DIV iterations; intermediate values SHALL be held internally only.

Reset
REQ-026 SHALL, while reset is low, asynchronously force state=IDLE, counter=0, HI=0, LO=0, BusyE=0, DivZero=0, and internal accumulators to 0. StallMDU then evaluates to 0.
REQ-027 SHALL, on reset assertion mid-operation, abort the operation with no HI/LO write; the first edge after deassertion SHALL be able to accept StartE.

Verification
REQ-028 Test 1: MULT, SrcA=7, SrcB=0xFFFFFFFD -> BusyE high 33 cycles; after edge 34, HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-029 Test 2: MULTU, SrcA=SrcB=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-030 Test 3: DIV, SrcA=0xFFFFFFF9 (-7), SrcB=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 Test 4: DIVU, SrcA=0x1234, SrcB=0 -> DivZero pulses in cycle 2; HI=0x1234, LO=0xFFFFFFFF; BusyE high for 1 cycle only.
REQ-032 Test 5: MduUseD=1 held from edge 3 of a MULT -> StallMDU=1 until state returns to IDLE, then 0. A second StartE during busy leaves HI/LO equal to the first result.
REQ-033 Test 6: reset low at iteration 10 of DIV with HI=LO=0xAAAA5555 preloaded via mthi/mtlo -> HI=LO=0, BusyE=0 immediately. A new MULT 3*4 after release -> LO=12, HI=0.
